// File: rtl/mux_2_1_32_if.sv
// Bus bundle for the fetch-stage next-PC selector: the two candidate PCs, the
// select, and the combinational and registered results.
interface mux_2_1_32_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sel;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] C_q;
  logic             Sel_q;

  // The master supplies the candidates and the select; the slave (the selector) answers.
  modport master (
    output A,
    output B,
    output Sel,
    input  C,
    input  C_q,
    input  Sel_q
  );

  modport slave (
    input  A,
    input  B,
    input  Sel,
    output C,
    output C_q,
    output Sel_q
  );
endinterface

// File: rtl/mux_2_1_32.sv
// Next-PC selector: C = Sel ? B : A with zero latency, plus a one-cycle
// registered copy of the choice (C_q) and of the select (Sel_q).
module mux_2_1_32 #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic        CLK,
  input  logic        Reset,
  mux_2_1_32_if.slave bus
);

  logic [WIDTH-1:0] c_sel;
  logic [WIDTH-1:0] C_d;
  logic             Sel_d;
  logic [WIDTH-1:0] C_q;
  logic             Sel_q;

  // Ternary, not if/else: an X select merges A and B instead of silently picking A.
  always_comb begin
    c_sel = bus.Sel ? bus.B : bus.A;
  end

  always_comb begin
    C_d   = c_sel;
    Sel_d = bus.Sel;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      C_q   <= RESET_VALUE;
      Sel_q <= 1'b0;
    end else begin
      C_q   <= C_d;
      Sel_q <= Sel_d;
    end
  end

  assign bus.C     = c_sel;
  assign bus.C_q   = C_q;
  assign bus.Sel_q = Sel_q;

endmodule

// File: tb/tb_mux_2_1_32.sv
// Directed-vector bench for the next-PC selector: combinational select,
// synchronous reset and its priority, one-cycle registered path, walking bits.
module tb_mux_2_1_32;

  logic CLK;
  logic Reset;
  int   checks;
  int   errors;

  mux_2_1_32_if #(.WIDTH(32)) bus ();

  mux_2_1_32 #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic test_comb_select();
    @(negedge CLK);
    bus.A = 32'h00003004; bus.B = 32'h00003100; bus.Sel = 1'b0;
    #1;
    checks++;
    if (bus.C !== 32'h00003004) begin
      errors++; $display("FAIL comb_sel0: C=%h required %h", bus.C, 32'h00003004);
    end
    bus.Sel = 1'b1;
    #1;
    checks++;
    if (bus.C !== 32'h00003100) begin
      errors++; $display("FAIL comb_sel1: C=%h required %h", bus.C, 32'h00003100);
    end
    $display("comb_select: A=%h B=%h C=%h", bus.A, bus.B, bus.C);
  endtask

  task automatic test_b_tracking();
    @(negedge CLK);
    bus.Sel = 1'b1; bus.A = 32'hA5A5A5A5; bus.B = 32'hFFFFFFFF;
    #1;
    checks++;
    if (bus.C !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL track_b_ones: C=%h required %h", bus.C, 32'hFFFFFFFF);
    end
    bus.B = 32'h00000000;
    #1;
    checks++;
    if (bus.C !== 32'h00000000) begin
      errors++; $display("FAIL track_b_zero: C=%h required %h", bus.C, 32'h00000000);
    end
    bus.A = 32'h5A5A5A5A;
    #1;
    checks++;
    if (bus.C !== 32'h00000000) begin
      errors++; $display("FAIL a_ignored: C=%h required %h", bus.C, 32'h00000000);
    end
    $display("b_tracking: C=%h", bus.C);
  endtask

  task automatic test_reset();
    // Load a non-zero value first so the reset is observable.
    @(negedge CLK);
    Reset = 1'b0; bus.Sel = 1'b1; bus.B = 32'h55555555;
    @(posedge CLK); #1;
    checks++;
    if (bus.C_q !== 32'h55555555 || bus.Sel_q !== 1'b1) begin
      errors++; $display("FAIL preload: C_q=%h Sel_q=%b required %h 1", bus.C_q, bus.Sel_q, 32'h55555555);
    end
    @(negedge CLK);
    Reset = 1'b1; bus.A = 32'h00001234; bus.Sel = 1'b0;
    #1;
    checks++;
    if (bus.C_q !== 32'h55555555 || bus.Sel_q !== 1'b1) begin
      errors++; $display("FAIL reset_sync: C_q=%h Sel_q=%b required %h 1", bus.C_q, bus.Sel_q, 32'h55555555);
    end
    checks++;
    if (bus.C !== 32'h00001234) begin
      errors++; $display("FAIL reset_comb_pre: C=%h required %h", bus.C, 32'h00001234);
    end
    @(posedge CLK); #1;
    checks++;
    if (bus.C_q !== 32'h0 || bus.Sel_q !== 1'b0) begin
      errors++; $display("FAIL reset_value: C_q=%h Sel_q=%b required 0 0", bus.C_q, bus.Sel_q);
    end
    checks++;
    if (bus.C !== 32'h00001234) begin
      errors++; $display("FAIL reset_comb_post: C=%h required %h", bus.C, 32'h00001234);
    end
    $display("reset: C_q=%h Sel_q=%b C=%h", bus.C_q, bus.Sel_q, bus.C);
  endtask

  task automatic test_registered();
    @(negedge CLK);
    Reset = 1'b0; bus.Sel = 1'b1; bus.B = 32'hDEADBEEF;
    @(posedge CLK); #1;
    checks++;
    if (bus.C_q !== 32'hDEADBEEF || bus.Sel_q !== 1'b1) begin
      errors++; $display("FAIL reg_b: C_q=%h Sel_q=%b required %h 1", bus.C_q, bus.Sel_q, 32'hDEADBEEF);
    end
    @(negedge CLK);
    bus.Sel = 1'b0; bus.A = 32'h00003008;
    @(posedge CLK); #1;
    checks++;
    if (bus.C_q !== 32'h00003008 || bus.Sel_q !== 1'b0) begin
      errors++; $display("FAIL reg_a: C_q=%h Sel_q=%b required %h 0", bus.C_q, bus.Sel_q, 32'h00003008);
    end
    $display("registered: C_q=%h Sel_q=%b", bus.C_q, bus.Sel_q);
  endtask

  task automatic test_reset_priority();
    @(negedge CLK);
    Reset = 1'b1; bus.B = 32'hCAFEBABE; bus.Sel = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (bus.C_q !== 32'h0 || bus.Sel_q !== 1'b0) begin
      errors++; $display("FAIL reset_priority: C_q=%h Sel_q=%b required 0 0", bus.C_q, bus.Sel_q);
    end
    @(negedge CLK);
    Reset = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (bus.C_q !== 32'hCAFEBABE || bus.Sel_q !== 1'b1) begin
      errors++; $display("FAIL reset_release: C_q=%h Sel_q=%b required %h 1", bus.C_q, bus.Sel_q, 32'hCAFEBABE);
    end
    $display("reset_priority: C_q=%h Sel_q=%b", bus.C_q, bus.Sel_q);
  endtask

  task automatic test_walking();
    logic [31:0] one_hot;
    logic [31:0] exp_c;
    for (int i = 0; i < 32; i++) begin
      for (int s = 0; s < 2; s++) begin
        one_hot = 32'h1 << i;
        exp_c   = (s == 1) ? ~one_hot : one_hot;
        @(negedge CLK);
        bus.A = one_hot; bus.B = ~one_hot; bus.Sel = (s == 1);
        #1;
        checks++;
        if (bus.C !== exp_c) begin
          errors++; $display("FAIL walk_comb bit %0d sel %0d: C=%h required %h", i, s, bus.C, exp_c);
        end
        @(posedge CLK); #1;
        checks++;
        if (bus.C_q !== exp_c || bus.Sel_q !== (s == 1)) begin
          errors++; $display("FAIL walk_reg bit %0d sel %0d: C_q=%h Sel_q=%b required %h %0d", i, s, bus.C_q, bus.Sel_q, exp_c, s);
        end
        $display("walk bit %0d sel %0d: C=%h C_q=%h", i, s, bus.C, bus.C_q);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b0;
    bus.A = '0; bus.B = '0; bus.Sel = 1'b0;
    test_comb_select();
    test_b_tracking();
    test_reset();
    test_registered();
    test_reset_priority();
    test_walking();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_2_1_32.md
Name: mux_2_1_32

Overview:
- 32-bit two-input selector. Used in the fetch stage to choose the next PC: A = PC+4 (sequential), B = NPC (branch/jump target).
- C = B when Sel=1, else A, combinationally, so the PC register sees the choice in the same cycle.
- Also provides a registered copy of the selected value, C_q, plus a registered select echo, Sel_q, for pipeline/debug observation.

Parameters:
- WIDTH, 32, data width of A, B, C, C_q.
- RESET_VALUE, 0 (WIDTH bits), value loaded into C_q on reset.

Ports:
- CLK  input  1  clock; rising-edge active.
- Reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  input selected when Sel=0 (PC+4 in fetch).
- B  input  WIDTH  input selected when Sel=1 (NPC in fetch).
- Sel  input  1  select: 0 -> A, 1 -> B.
- C  output  WIDTH  combinational selected value.
- C_q  output  WIDTH  registered selected value.
- Sel_q  output  1  registered Sel.

Behaviour:
- C = Sel ? B : A.
  - Purely combinational; zero-cycle latency.
  - No dependence on CLK or Reset; valid during reset.
- Full-width pass-through: no truncation, extension or bit reordering. Every bit of C equals the same bit of the chosen input.
- Sel of X/Z: no functional requirement. Simulation should propagate X. No latch is inferred.
- Registered path, on rising CLK:
  - If Reset=1: C_q <= RESET_VALUE, Sel_q <= 0.
  - Otherwise: C_q <= C (value present just before the edge), Sel_q <= Sel.
- Latency: C_q and Sel_q lag C and Sel by exactly one cycle.
- Reset is synchronous only. Asserting it mid-cycle does not change C_q or Sel_q until the next rising edge.
- Reset has priority over any simultaneous change of A, B or Sel at that edge.
- There is no enable or stall input. Stalling is handled by the consumer (the PC register), so C_q updates every non-reset cycle.
- Initial (pre-reset) value of C_q and Sel_q is undefined. Consumers must apply Reset before use.
- No internal state other than C_q and Sel_q.

Test Plan:
- A=32'h00003004, B=32'h00003100, Sel=0 -> C=32'h00003004 immediately. Toggle Sel=1 -> C=32'h00003100 in the same delta, no clock needed.
- Sel=1, change B from 32'hFFFFFFFF to 32'h00000000 while A is held at 32'hA5A5A5A5 -> C tracks B only. Changing A has no effect on C.
- Reset=1 for one edge with A=32'h1234, Sel=0 -> after the edge C_q=0 and Sel_q=0, while C=32'h1234 throughout.
- Reset=0, Sel=1, B=32'hDEADBEEF, one edge -> C_q=32'hDEADBEEF, Sel_q=1. Next edge with Sel=0, A=32'h00003008 -> C_q=32'h00003008, Sel_q=0.
- Reset=1 coincident with Sel/B change at the edge (B=32'hCAFEBABE, Sel=1) -> C_q=0, Sel_q=0. Release Reset -> the next edge loads 32'hCAFEBABE.
- Walking-ones on A and walking-zeros on B, all 32 positions, both Sel values -> C matches the selected input bit-exactly. C_q matches one cycle later.
